alu_serial_ctrl: RTL and testbench

Bit-serial ALU sequencer. It computes a WIDTH-bit ALU operation by driving one 1-bit ALU slice for WIDTH cycles, LSB first. It holds the carry between cycles and applies the set-less-than correction at the end. It sits between the issue logic and the register-file write port, and gives a small-area alternative to the full ripple ALU.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_serial_bit.sv | 39 +++
 rtl/alu_serial_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared encodings for the bit-serial ALU (ALU_control codes, slice ops, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // ALU_control encodings seen on the issue interface
    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    // 1-bit slice operation select
    localparam logic [1:0] SLICE_AND = 2'b00;
    localparam logic [1:0] SLICE_OR  = 2'b01;
    localparam logic [1:0] SLICE_ADD = 2'b10;
    localparam logic [1:0] SLICE_SET = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Decoded controls, latched once per operation
    typedef struct packed {
        logic       a_invert;
        logic       b_invert;
        logic [1:0] op;
        logic       arith;   // ADD/SUB: drives cout and overflow
        logic       slt;     // needs the FIX cycle
        logic       legal;   // unsupported codes force a zero result
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [3:0] code);
        ctrl_t d;
        d       = '0;
        d.op    = SLICE_AND;
        d.legal = 1'b1;
        case (code)
            ALU_CTRL_AND: d.op = SLICE_AND;
            ALU_CTRL_OR:  d.op = SLICE_OR;
            ALU_CTRL_ADD: begin
                d.op    = SLICE_ADD;
                d.arith = 1'b1;
            end
            ALU_CTRL_SUB: begin
                d.op       = SLICE_ADD;
                d.b_invert = 1'b1;
                d.arith    = 1'b1;
            end
            ALU_CTRL_SLT: begin
                d.op       = SLICE_SET;
                d.b_invert = 1'b1;
                d.slt      = 1'b1;
            end
            ALU_CTRL_NOR: begin
                d.op       = SLICE_AND;
                d.a_invert = 1'b1;
                d.b_invert = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// Purpose: combinational 1-bit ALU slice (and/or/add/set with operand inversion).
// Latency: zero cycles, purely combinational.
// Backpressure: none; evaluated every cycle the controller drives it.
// Ports: a, b operand bits; A_invert/B_invert invert them; cin carry in; op slice select;
//        result selected output bit; cout carry out; sum full-adder sum (used for SLT sign).
module alu_serial_bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout,
    output logic       sum
);

    logic a_eff;
    logic b_eff;

    always_comb begin
        a_eff  = a ^ A_invert;
        b_eff  = b ^ B_invert;
        sum    = a_eff ^ b_eff ^ cin;
        cout   = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
        result = 1'b0;
        case (op)
            SLICE_AND: result = a_eff & b_eff;
            SLICE_OR:  result = a_eff | b_eff;
            SLICE_ADD: result = sum;
            // SET yields 0 in every position; the controller fills bit 0
            // with the corrected sign during the FIX cycle.
            default:   result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Purpose: bit-serial ALU sequencer driving one 1-bit slice LSB first for WIDTH cycles.
// Latency: done WIDTH cycles after the accepting edge (WIDTH+1 for SLT); start accepted in the done cycle.
// Backpressure: none; start is only sampled while idle, starts during busy are dropped.
// Ports: clk, rst (sync, active-high); start/ALU_control/src1/src2 request;
//        busy, done pulse, result/zero/cout/overflow held from done until the next done.
// WIDTH must be >= 2 and 2**CNT_W must exceed WIDTH.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_bit;

    ctrl_t            ctrl_d;
    ctrl_t            ctrl_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 bits already produced; the final bit joins them in
    // the last RUN cycle, so the full word never needs to be stored here.
    logic [WIDTH-2:0] result_sr;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             slt_ovf_q;
    logic             slt_sum_q;

    logic             slice_res;
    logic             slice_cout;
    logic             slice_sum;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] final_res;
    logic             msb_ovf;
    logic             slt_bit;

    assign ctrl_d = decode_ctrl(ALU_control);

    alu_serial_bit u_bit (
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .A_invert (ctrl_q.a_invert),
        .B_invert (ctrl_q.b_invert),
        .cin      (carry_q),
        .op       (ctrl_q.op),
        .result   (slice_res),
        .cout     (slice_cout),
        .sum      (slice_sum)
    );

    assign res_next  = {slice_res, result_sr};
    assign final_res = ctrl_q.legal ? res_next : '0;
    // In the MSB cycle carry_q is the carry into the MSB.
    assign msb_ovf   = carry_q ^ slice_cout;
    // Sign of a-b corrected for signed overflow gives the less-than bit.
    assign slt_bit   = slt_sum_q ^ slt_ovf_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_bit = 1'b1;
                    state_d  = ctrl_q.slt ? FIX : IDLE;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            result_sr <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            slt_ovf_q <= 1'b0;
            slt_sum_q <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ctrl_q    <= ctrl_d;
                a_sr      <= src1;
                b_sr      <= src2;
                result_sr <= '0;
                cnt_q     <= '0;
                // Subtraction forms a + ~b + 1; NOR inverts b but must not add.
                carry_q   <= ctrl_d.b_invert & (ctrl_d.arith | ctrl_d.slt);
            end else if (state_q == RUN) begin
                a_sr      <= a_sr >> 1;
                b_sr      <= b_sr >> 1;
                result_sr <= res_next[WIDTH-1:1];
                carry_q   <= slice_cout;
                cnt_q     <= cnt_q + CNT_W'(1);
                if (last_bit) begin
                    if (ctrl_q.slt) begin
                        slt_ovf_q <= msb_ovf;
                        slt_sum_q <= slice_sum;
                    end else begin
                        done     <= 1'b1;
                        result   <= final_res;
                        zero     <= (final_res == '0);
                        cout     <= ctrl_q.arith & slice_cout;
                        overflow <= ctrl_q.arith & msb_ovf;
                    end
                end
            end else if (state_q == FIX) begin
                done     <= 1'b1;
                result   <= {{(WIDTH-1){1'b0}}, slt_bit};
                zero     <= ~slt_bit;
                cout     <= 1'b0;
                overflow <= slt_ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Purpose: self-checking bench for alu_serial_ctrl with a scoreboard and arithmetic reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   ctl = 4'b0000;
    logic [W-1:0] s1 = '0;
    logic [W-1:0] s2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         co;
        logic         ov;
        int           t;    // edge after which done must be visible
    } exp_t;

    exp_t         q[$];
    exp_t         hold;
    int           cyc = 0;
    int           done_t = 0;
    int           total = 0;
    int           passed = 0;

    alu_serial_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ALU_control (ctl),
        .src1        (s1),
        .src2        (s2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: plain two's-complement arithmetic on whole words.
    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int t0);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] diff;
        e.r  = '0;
        e.co = 1'b0;
        e.ov = 1'b0;
        e.t  = t0 + W;
        diff = a - b;
        case (c)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b1100: e.r = ~(a | b);
            4'b0010: begin
                s    = {1'b0, a} + {1'b0, b};
                e.r  = s[W-1:0];
                e.co = s[W];
                e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            4'b0110: begin
                s    = {1'b0, a} + {1'b0, ~b} + 1;
                e.r  = s[W-1:0];
                e.co = s[W];
                e.ov = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            4'b0111: begin
                e.r  = ($signed(a) < $signed(b)) ? 1 : 0;
                e.ov = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
                e.t  = t0 + W + 1;
            end
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Acceptance model: a start is taken at an edge only once the previous
    // operation's done cycle has been reached.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
            hold.r  = '0;
            hold.z  = 1'b0;
            hold.co = 1'b0;
            hold.ov = 1'b0;
            done_t  = cyc;
        end else if (start && cyc > done_t) begin
            e = model(ctl, s1, s2, cyc);
            q.push_back(e);
            done_t = e.t;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        chk("busy", {31'b0, busy}, {31'b0, (q.size() > 0) && (cyc < done_t)});
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, '0);
            end else begin
                e = q.pop_front();
                chk("done_edge", cyc, e.t);
                chk("result", result, e.r);
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("cout", {31'b0, cout}, {31'b0, e.co});
                chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
                hold = e;
            end
        end else if (q.size() > 0 && cyc >= q[0].t) begin
            chk("missing_done", {31'b0, done}, 32'd1);
            hold = q.pop_front();
        end else begin
            chk("result_hold", result, hold.r);
            chk("zero_hold", {31'b0, zero}, {31'b0, hold.z});
            chk("cout_hold", {31'b0, cout}, {31'b0, hold.co});
            chk("ovf_hold", {31'b0, overflow}, {31'b0, hold.ov});
        end
    end

    // Waits until the model reports idle, then holds start for one edge and
    // scrambles the inputs afterwards to prove they were latched.
    task automatic go(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        while (cyc < done_t) @(negedge clk);
        start = 1'b1;
        ctl   = c;
        s1    = a;
        s2    = b;
        @(negedge clk);
        start = 1'b0;
        ctl   = 4'($urandom);
        s1    = $urandom;
        s2    = $urandom;
    endtask

    task automatic poke();
        @(negedge clk);
        start = 1'b1;
        ctl   = 4'($urandom);
        s1    = $urandom;
        s2    = $urandom;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_after(input int n);
        repeat (n) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   ops[7];
        logic [W-1:0] corner[5];
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        ops    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};
        corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        go(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        go(4'b0110, 32'h0000_0005, 32'h0000_0005);
        go(4'b0111, 32'hFFFF_FFFD, 32'h0000_0002);
        go(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        go(4'b1100, 32'h0000_0000, 32'h0F0F_0F0F);
        go(4'b0001, 32'h00FF_0000, 32'h0000_00FF);

        // Starts during busy must be ignored
        go(4'b0010, 32'h1234_5678, 32'h1111_1111);
        poke();
        repeat (5) @(negedge clk);
        poke();
        poke();

        // Reset at the tenth edge after acceptance, then a clean operation
        go(4'b0010, 32'hDEAD_BEEF, 32'h0000_1000);
        reset_after(9);
        go(4'b0010, 32'h0000_0003, 32'h0000_0004);

        // Unsupported control code
        go(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 70; i++) begin
            c = ops[$urandom_range(0, 6)];
            if (c == 4'b1111) c = 4'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            go(c, a, b);
            if ($urandom_range(0, 2) == 0) poke();
            if ($urandom_range(0, 15) == 0) reset_after($urandom_range(1, 25));
            else if ($urandom_range(0, 3) == 0) repeat ($urandom_range(30, 40)) @(negedge clk);
        end

        @(negedge clk);
        while (cyc <= done_t) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
